// File: rtl/cmp_share_arbiter_if.sv
// cmp_share_arbiter_if: client-side request bus and tagged result bus of the shared comparator
interface cmp_share_arbiter_if #(
    parameter int NREQ = 4,
    parameter int W    = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] a_in;
    logic [NREQ*W-1:0] b_in;
    logic [NREQ-1:0]   sgn_in;
    logic [NREQ-1:0]   ack;
    logic              busy;
    logic              res_valid;
    logic [IDW-1:0]    res_id;
    logic              res_v;
    logic              res_n;
    logic              res_z;
    logic              res_c;
    logic              res_lt;
    logic              res_eq;
    logic              res_gt;

    modport master (
        output req, a_in, b_in, sgn_in,
        input  ack, busy, res_valid, res_id, res_v, res_n, res_z, res_c, res_lt, res_eq, res_gt
    );

    modport slave (
        input  req, a_in, b_in, sgn_in,
        output ack, busy, res_valid, res_id, res_v, res_n, res_z, res_c, res_lt, res_eq, res_gt
    );
endinterface

// File: rtl/cmp_share_arbiter.sv
// cmp_share_arbiter: round-robin sharing of one ripple-carry subtract comparator, 2-stage pipeline
module cmp_share_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 4,
    parameter int IDW  = 2
) (
    input logic clk,
    input logic rst,
    cmp_share_arbiter_if.slave bus
);
    logic [IDW-1:0] rr;
    logic [IDW-1:0] win;
    logic [IDW-1:0] idx;
    logic [IDW-1:0] id1;
    logic           found;
    logic           v1;
    logic           sg1;
    logic [W-1:0]   a1;
    logic [W-1:0]   b1;
    logic [W-1:0]   s;
    logic [W:0]     cy;
    logic           ovf;
    logic           lt;

    // search requests starting at the round-robin pointer, wrapping past NREQ-1
    always_comb begin
        found = 1'b0;
        win = rr;
        idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IDW'((int'(rr) + k) % NREQ);
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                win = idx;
            end
        end
    end

    assign bus.ack  = (found && !rst) ? ({{(NREQ-1){1'b0}}, 1'b1} << win) : '0;
    assign bus.busy = v1 | bus.res_valid;

    // ripple-carry A + ~B + 1 on the stage-1 operands, keeping every carry
    always_comb begin
        cy = {{W{1'b0}}, 1'b1};
        s = '0;
        for (int i = 0; i < W; i++) begin
            s[i] = a1[i] ^ ~b1[i] ^ cy[i];
            cy[i+1] = (a1[i] & ~b1[i]) | (cy[i] & (a1[i] ^ ~b1[i]));
        end
    end

    assign ovf = cy[W] ^ cy[W-1];
    assign lt  = sg1 ? (s[W-1] ^ ovf) : ~cy[W];

    // advance the pointer past the winner; hold it when nobody is granted
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rr <= '0;
        else if (found)
            rr <= (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
    end

    // stage 1: capture the granted requester's operands, mode and id
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1  <= 1'b0;
            id1 <= '0;
            a1  <= '0;
            b1  <= '0;
            sg1 <= 1'b0;
        end else begin
            v1 <= found;
            if (found) begin
                id1 <= win;
                a1  <= bus.a_in[win*W +: W];
                b1  <= bus.b_in[win*W +: W];
                sg1 <= bus.sgn_in[win];
            end
        end
    end

    // stage 2: register the flags and decoded relation; flags hold between strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.res_valid <= 1'b0;
            bus.res_id    <= '0;
            bus.res_v     <= 1'b0;
            bus.res_n     <= 1'b0;
            bus.res_z     <= 1'b0;
            bus.res_c     <= 1'b0;
            bus.res_lt    <= 1'b0;
            bus.res_eq    <= 1'b0;
            bus.res_gt    <= 1'b0;
        end else begin
            bus.res_valid <= v1;
            if (v1) begin
                bus.res_id <= id1;
                bus.res_v  <= ovf;
                bus.res_n  <= s[W-1];
                bus.res_z  <= ~|s;
                bus.res_c  <= cy[W];
                bus.res_lt <= lt;
                bus.res_eq <= ~|s;
                bus.res_gt <= ~lt & (|s);
            end
        end
    end
endmodule

// File: tb/tb_cmp_share_arbiter.sv
// tb_cmp_share_arbiter: directed and randomized checks of the shared comparator against an integer model
module tb_cmp_share_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 4;
    localparam int IDW  = 2;

    typedef struct packed {
        logic v, n, z, c, lt, eq, gt;
    } flags_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;

    cmp_share_arbiter_if #(.NREQ(NREQ), .W(W), .IDW(IDW)) bus();

    cmp_share_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    flags_t dflags;
    assign dflags = {bus.res_v, bus.res_n, bus.res_z, bus.res_c, bus.res_lt, bus.res_eq, bus.res_gt};

    // model: pointer, granted op one edge later, result two edges later
    int              mrr = 0;
    bit              m1v = 0;
    int              m1id = 0;
    flags_t          m1f = '0;
    bit              mov = 0;
    int              moid = 0;
    flags_t          mof = '0;
    logic [NREQ-1:0] mack = '0;

    // comparison outcome from plain integer arithmetic on the operand values
    function automatic flags_t calc(int a, int b, bit sg);
        flags_t f;
        int sa, sb, d, m;
        m  = 1 << W;
        sa = (a >= m / 2) ? a - m : a;
        sb = (b >= m / 2) ? b - m : b;
        d  = sa - sb;
        f.v  = (d < -(m / 2)) || (d > m / 2 - 1);
        f.n  = (((a - b) & (m - 1)) >= m / 2);
        f.z  = (a == b);
        f.c  = (a >= b);
        f.lt = sg ? (sa < sb) : (a < b);
        f.eq = f.z;
        f.gt = !f.lt && !f.eq;
        return f;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic out_check();
        chk("res_valid", 32'(bus.res_valid), 32'(mov));
        chk("busy", 32'(bus.busy), 32'(m1v | mov));
        chk("res_id", 32'(bus.res_id), 32'(moid));
        chk("flags", 32'(dflags), 32'(mof));
    endtask

    task automatic tick_check();
        @(negedge clk);
        out_check();
    endtask

    // apply one cycle of inputs, check the combinational grant, then advance the model
    task automatic drive(input logic r_st, input logic [NREQ-1:0] r,
                         input logic [NREQ*W-1:0] a, input logic [NREQ*W-1:0] b,
                         input logic [NREQ-1:0] sg);
        int win;
        int idx;
        rst = r_st;
        bus.req = r;
        bus.a_in = a;
        bus.b_in = b;
        bus.sgn_in = sg;
        #1;
        win = -1;
        if (!r_st)
            for (int k = 0; k < NREQ; k++) begin
                idx = (mrr + k) % NREQ;
                if (win < 0 && |(r & (NREQ'(1) << idx))) win = idx;
            end
        mack = (win < 0) ? '0 : (NREQ'(1) << win);
        chk("ack", 32'(bus.ack), 32'(mack));
        if (r_st) begin
            mrr = 0; m1v = 0; mov = 0; m1id = 0; moid = 0; m1f = '0; mof = '0;
            out_check();
        end else begin
            mov = m1v;
            if (m1v) begin
                moid = m1id;
                mof = m1f;
            end
            m1v = (win >= 0);
            if (win >= 0) begin
                m1id = win;
                m1f = calc(int'(a[win*W +: W]), int'(b[win*W +: W]), sg[win]);
                mrr = (win + 1) % NREQ;
            end
        end
    endtask

    task automatic step(input logic r_st, input logic [NREQ-1:0] r,
                        input logic [NREQ*W-1:0] a, input logic [NREQ*W-1:0] b,
                        input logic [NREQ-1:0] sg);
        tick_check();
        drive(r_st, r, a, b, sg);
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, '0, '0);
    endtask

    logic [NREQ-1:0]   rq;
    logic [NREQ-1:0]   rsg;
    logic [NREQ*W-1:0] ra;
    logic [NREQ*W-1:0] rb;

    initial begin
        bus.req = '0;
        bus.a_in = '0;
        bus.b_in = '0;
        bus.sgn_in = '0;
        tick_check();
        drive(1'b1, '0, '0, '0, '0);

        // signed 3 vs 5 on requester 0
        step(1'b0, 4'b0001, 16'h0003, 16'h0005, 4'b0001);
        chk("t1 ack", 32'(bus.ack), 32'h1);
        step(1'b0, '0, '0, '0, '0);
        tick_check();
        chk("t1 valid", 32'(bus.res_valid), 32'h1);
        chk("t1 id", 32'(bus.res_id), 32'h0);
        chk("t1 nv/lt/eq/gt", 32'({bus.res_n, bus.res_v, bus.res_lt, bus.res_eq, bus.res_gt}), 32'b10100);
        idle();

        // -8 vs 1 signed then unsigned, back to back from the same requester
        step(1'b0, 4'b0001, 16'h0008, 16'h0001, 4'b0001);
        step(1'b0, 4'b0001, 16'h0008, 16'h0001, 4'b0000);
        chk("t2 held ack", 32'(bus.ack), 32'h1);
        step(1'b0, '0, '0, '0, '0);
        chk("t2s v/n/lt", 32'({bus.res_v, bus.res_n, bus.res_lt}), 32'b101);
        tick_check();
        chk("t2u valid", 32'(bus.res_valid), 32'h1);
        chk("t2u c/gt", 32'({bus.res_c, bus.res_gt}), 32'b11);
        idle();

        // equality 6 vs 6 in both modes
        step(1'b0, 4'b0001, 16'h0006, 16'h0006, 4'b0001);
        step(1'b0, 4'b0001, 16'h0006, 16'h0006, 4'b0000);
        step(1'b0, '0, '0, '0, '0);
        chk("t3s z/c/lt/eq/gt", 32'({bus.res_z, bus.res_c, bus.res_lt, bus.res_eq, bus.res_gt}), 32'b11010);
        tick_check();
        chk("t3u z/c/lt/eq/gt", 32'({bus.res_z, bus.res_c, bus.res_lt, bus.res_eq, bus.res_gt}), 32'b11010);
        idle();

        // round robin from pointer 0 with all four requesting
        tick_check();
        drive(1'b1, '0, '0, '0, '0);
        for (int i = 0; i < 10; i++) begin
            tick_check();
            if (i >= 2) begin
                chk("rr valid", 32'(bus.res_valid), 32'h1);
                chk("rr id", 32'(bus.res_id), 32'((i - 2) % NREQ));
            end
            if (i < 8) begin
                drive(1'b0, 4'hF, 16'h7531, 16'h2468, 4'b0101);
                chk("rr ack", 32'(bus.ack), 32'(1 << (i % NREQ)));
            end else
                idle();
        end

        // move pointer to 2, then requesters 1 and 3 alternate
        step(1'b0, 4'b0010, 16'h0050, 16'h0030, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 4'b1010, 16'h9050, 16'h3030, 4'b1000);
            chk("fair ack", 32'(bus.ack), (i % 2 == 0) ? 32'h8 : 32'h2);
        end
        step(1'b0, '0, '0, '0, '0);
        step(1'b0, '0, '0, '0, '0);
        step(1'b0, '0, '0, '0, '0);

        // reset in the cycle after a grant drops the op
        step(1'b0, 4'b0001, 16'h0002, 16'h0001, 4'b0000);
        chk("rst grant", 32'(bus.ack), 32'h1);
        tick_check();
        drive(1'b1, '0, '0, '0, '0);
        chk("rst busy", 32'(bus.busy), 32'h0);
        tick_check();
        chk("rst no valid", 32'(bus.res_valid), 32'h0);
        drive(1'b0, 4'b1100, 16'h4400, 16'h1100, 4'b0000);
        chk("rst first ack", 32'(bus.ack), 32'h4);
        step(1'b0, 4'b1000, 16'h4400, 16'h1100, 4'b0000);
        chk("rst second ack", 32'(bus.ack), 32'h8);
        step(1'b0, '0, '0, '0, '0);
        step(1'b0, '0, '0, '0, '0);

        // random traffic honouring the hold-until-ack rule, occasional reset
        rq = '0; rsg = '0; ra = '0; rb = '0;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NREQ; i++)
                if (!rq[i] || mack[i]) begin
                    rq[i] = ($urandom_range(0, 2) != 0);
                    ra[i*W +: W] = W'($urandom);
                    rb[i*W +: W] = ($urandom_range(0, 3) == 0) ? ra[i*W +: W] : W'($urandom);
                    rsg[i] = 1'($urandom);
                end
            step(($urandom_range(0, 199) == 0), rq, ra, rb, rsg);
        end
        for (int i = 0; i < 4; i++) step(1'b0, '0, '0, '0, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
